ex_mem_pipe_reg: RTL and testbench

//  EX/MEM pipeline register for the 16-bit WISC core, directly downstream of the EX-stage result mux (ALU/RED_Unit output).

---
 rtl/ex_mem_pipe_reg.sv | 80 ++++++++
 tb/tb_ex_mem_pipe_reg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: EX/MEM pipeline register with stall, flush, sticky halt, forwarding/load-use flags and RED retire counter
//   clk, rst                  clock, synchronous active-high reset
//   stall, flush              hold all state / insert bubble (flush wins)
//   ex_*                      EX-stage instruction fields and controls
//   id_rs, id_rt              ID/EX source registers for hazard compare
//   mem_*                     registered instruction fields and controls
//   mem_halt                  sticky halt flag, cleared only by rst
//   fwd_rs_hit, fwd_rt_hit    forward mem_result to rs / rt operand
//   load_use                  LW in MEM feeds rs/rt, stall request
//   red_count                 count of RED instructions captured
module ex_mem_pipe_reg #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic              ex_is_red,
    input  logic              ex_halt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_regwrite,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic              mem_halt,
    output logic              fwd_rs_hit,
    output logic              fwd_rt_hit,
    output logic              load_use,
    output logic [CNT_W-1:0]  red_count
);
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_regwrite   <= 1'b0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            mem_halt       <= 1'b0;
            red_count      <= '0;
        end else if (mem_halt || flush) begin
            // bubble: data fields and halt flag are left as they are
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
        end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_result     <= ex_result;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
            // writes to R0 are dropped here so hazard logic never matches R0
            mem_regwrite   <= ex_valid && ex_regwrite && (ex_rd != '0);
            mem_memread    <= ex_valid && ex_memread;
            mem_memwrite   <= ex_valid && ex_memwrite;
            mem_halt       <= ex_valid && ex_halt;
            red_count      <= red_count + CNT_W'(ex_valid && ex_is_red);
        end
    end

    always_comb begin
        fwd_rs_hit = mem_valid && mem_regwrite && !mem_memread && (mem_rd == id_rs);
        fwd_rt_hit = mem_valid && mem_regwrite && !mem_memread && (mem_rd == id_rt);
        load_use   = mem_valid && mem_memread && mem_regwrite && ((mem_rd == id_rs) || (mem_rd == id_rt));
    end
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb_ex_mem_pipe_reg: directed bench with a behavioural model checked every cycle plus literal spot checks
module tb_ex_mem_pipe_reg;
    logic        clk = 1'b0;
    logic        rst, stall, flush, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_is_red, ex_halt;
    logic [15:0] ex_result, ex_store_data, mem_result, mem_store_data, red_count;
    logic [3:0]  ex_rd, id_rs, id_rt, mem_rd;
    logic        mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_halt, fwd_rs_hit, fwd_rt_hit, load_use;
    int          ncmp = 0, nfail = 0;
    logic        cmp_en = 1'b0;

    ex_mem_pipe_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_is_red(ex_is_red), .ex_halt(ex_halt), .id_rs(id_rs), .id_rt(id_rt),
        .mem_valid(mem_valid), .mem_result(mem_result), .mem_store_data(mem_store_data),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_halt(mem_halt), .fwd_rs_hit(fwd_rs_hit),
        .fwd_rt_hit(fwd_rt_hit), .load_use(load_use), .red_count(red_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [15:0] res, sd;
        logic [3:0]  rd;
        logic        rw, mr, mw, hlt;
        logic [15:0] cnt;
    } st_t;
    st_t e;

    // Expected MEM stage: what the instruction in MEM must look like after each edge
    always @(posedge clk) begin
        if (rst) e <= '0;
        else if (e.hlt || flush) begin
            e.v <= 1'b0; e.rw <= 1'b0; e.mr <= 1'b0; e.mw <= 1'b0;
        end else if (!stall) begin
            e.v   <= ex_valid;
            e.res <= ex_result;
            e.sd  <= ex_store_data;
            e.rd  <= ex_rd;
            e.rw  <= ex_valid && ex_regwrite && ex_rd != 4'd0;
            e.mr  <= ex_valid && ex_memread;
            e.mw  <= ex_valid && ex_memwrite;
            e.hlt <= ex_valid && ex_halt;
            if (ex_valid && ex_is_red) e.cnt <= e.cnt + 16'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_valid", 32'(mem_valid), 32'(e.v));
            chk("m_rd", 32'(mem_rd), 32'(e.rd));
            chk("m_regwrite", 32'(mem_regwrite), 32'(e.rw));
            chk("m_memread", 32'(mem_memread), 32'(e.mr));
            chk("m_memwrite", 32'(mem_memwrite), 32'(e.mw));
            chk("m_halt", 32'(mem_halt), 32'(e.hlt));
            chk("m_red_count", 32'(red_count), 32'(e.cnt));
            chk("m_fwd_rs", 32'(fwd_rs_hit), 32'(e.v && e.rw && !e.mr && e.rd == id_rs));
            chk("m_fwd_rt", 32'(fwd_rt_hit), 32'(e.v && e.rw && !e.mr && e.rd == id_rt));
            chk("m_load_use", 32'(load_use), 32'(e.v && e.mr && e.rw && (e.rd == id_rs || e.rd == id_rt)));
            if (e.v) begin
                chk("m_result", 32'(mem_result), 32'(e.res));
                chk("m_store", 32'(mem_store_data), 32'(e.sd));
            end
        end
    end

    task automatic drive(input logic v, input logic [15:0] res, input logic [15:0] sd, input logic [3:0] rd,
                         input logic rw, input logic mr, input logic mw, input logic red, input logic hlt);
        ex_valid = v; ex_result = res; ex_store_data = sd; ex_rd = rd;
        ex_regwrite = rw; ex_memread = mr; ex_memwrite = mw; ex_is_red = red; ex_halt = hlt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; id_rs = 4'd0; id_rt = 4'd0;
        drive(0, 16'h0, 16'h0, 4'd0, 0, 0, 0, 0, 0);
        tick();
        cmp_en = 1'b1;
        tick();
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_count", 32'(red_count), 32'd0);
        chk("rst_halt", 32'(mem_halt), 32'd0);
        // 1: ADD r3
        rst = 1'b0;
        drive(1, 16'h1234, 16'h0011, 4'd3, 1, 0, 0, 0, 0);
        tick();
        chk("add_valid", 32'(mem_valid), 32'd1);
        chk("add_result", 32'(mem_result), 32'h1234);
        chk("add_rd", 32'(mem_rd), 32'd3);
        chk("add_rw", 32'(mem_regwrite), 32'd1);
        // 2: RED r5 then stall 3 cycles
        drive(1, 16'hFFF9, 16'h0022, 4'd5, 1, 0, 0, 1, 0);
        id_rs = 4'd5;
        tick();
        chk("red_result", 32'(mem_result), 32'hFFF9);
        chk("red_fwd_rs", 32'(fwd_rs_hit), 32'd1);
        chk("red_count1", 32'(red_count), 32'd1);
        stall = 1'b1;
        drive(1, 16'hAAAA, 16'h5555, 4'd7, 1, 0, 0, 1, 0);
        repeat (3) tick();
        chk("stall_result", 32'(mem_result), 32'hFFF9);
        chk("stall_rd", 32'(mem_rd), 32'd5);
        chk("stall_count", 32'(red_count), 32'd1);
        stall = 1'b0;
        // 3: LW r2 with id_rt=2, then same with flush+stall
        id_rs = 4'd7; id_rt = 4'd2;
        drive(1, 16'h0040, 16'h0000, 4'd2, 1, 1, 0, 0, 0);
        tick();
        chk("lw_load_use", 32'(load_use), 32'd1);
        chk("lw_fwd_rt", 32'(fwd_rt_hit), 32'd0);
        flush = 1'b1; stall = 1'b1;
        tick();
        chk("flush_valid", 32'(mem_valid), 32'd0);
        chk("flush_load_use", 32'(load_use), 32'd0);
        flush = 1'b0; stall = 1'b0;
        // SW with store data
        drive(1, 16'h0080, 16'hBEEF, 4'd9, 0, 0, 1, 0, 0);
        tick();
        chk("sw_store", 32'(mem_store_data), 32'hBEEF);
        chk("sw_memwrite", 32'(mem_memwrite), 32'd1);
        // invalid instruction: controls gated off
        drive(0, 16'h0001, 16'h0002, 4'd4, 1, 1, 1, 1, 1);
        tick();
        chk("inv_rw", 32'(mem_regwrite), 32'd0);
        chk("inv_halt", 32'(mem_halt), 32'd0);
        // 4: ADD r0
        id_rs = 4'd0; id_rt = 4'd0;
        drive(1, 16'h7777, 16'h0000, 4'd0, 1, 0, 0, 0, 0);
        tick();
        chk("r0_rw", 32'(mem_regwrite), 32'd0);
        chk("r0_fwd_rs", 32'(fwd_rs_hit), 32'd0);
        // 5: HLT, then sticky bubbles through flush/stall, then reset while stalled
        drive(1, 16'h0000, 16'h0000, 4'd0, 0, 0, 0, 0, 1);
        tick();
        chk("hlt_halt", 32'(mem_halt), 32'd1);
        chk("hlt_valid", 32'(mem_valid), 32'd1);
        id_rs = 4'd3;
        drive(1, 16'h4321, 16'h0000, 4'd3, 1, 0, 0, 1, 0);
        tick();
        chk("halted_valid", 32'(mem_valid), 32'd0);
        chk("halted_fwd", 32'(fwd_rs_hit), 32'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        stall = 1'b1; tick();
        chk("halted_sticky", 32'(mem_halt), 32'd1);
        chk("halted_count", 32'(red_count), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0; stall = 1'b0;
        chk("rst_halt_clr", 32'(mem_halt), 32'd0);
        chk("rst_count_clr", 32'(red_count), 32'd0);
        // 6: wrap red_count
        cmp_en = 1'b0;
        drive(1, 16'h0001, 16'h0000, 4'd6, 1, 0, 0, 1, 0);
        repeat (65535) @(posedge clk);
        #1;
        ex_valid = 1'b0;
        cmp_en = 1'b1;
        chk("cnt_ffff", 32'(red_count), 32'hFFFF);
        tick();
        chk("cnt_hold_invalid", 32'(red_count), 32'hFFFF);
        ex_valid = 1'b1;
        tick();
        chk("cnt_wrap", 32'(red_count), 32'h0000);
        ex_valid = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
